// File: rtl/mem_mapped_reg_bank_if.sv
// Data-memory bus bundle seen by a memory-mapped register bank.
// Ports:
//   mem_addr   address from the CPU
//   mem_wr_en  write strobe
//   mem_rd_en  read strobe
//   data_in    write data from the CPU
//   data_out   registered read data (zero when the bank is not selected)
//   rd_valid   high the cycle after a read that hit the bank
interface mem_mapped_reg_bank_if #(
   parameter int ADDR_W = 16,
   parameter int WIDTH  = 16
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wr_en;
   logic              mem_rd_en;
   logic [WIDTH-1:0]  data_in;
   logic [WIDTH-1:0]  data_out;
   logic              rd_valid;

   modport master (
      output mem_addr, mem_wr_en, mem_rd_en, data_in,
      input  data_out, rd_valid
   );

   modport slave (
      input  mem_addr, mem_wr_en, mem_rd_en, data_in,
      output data_out, rd_valid
   );
endinterface

// File: rtl/mem_mapped_reg_bank.sv
// Bank of NREGS memory-mapped registers at consecutive addresses from BASE.
// Each register is plain read/write or sticky status (write-one-to-clear).
// Read data is forced to zero when the bank is not selected so several banks
// can be OR-combined onto one read bus.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   bus        slave side of the data-memory bus (addr, strobes, data, rd_valid)
//   hw_set     per-bit set requests, reg i at [i*WIDTH +: WIDTH] (sticky regs only)
//   reg_out    live register contents, reg i at [i*WIDTH +: WIDTH]
//   wr_pulse   bit i pulses one cycle after a bus write to reg i
module mem_mapped_reg_bank #(
   parameter int                         WIDTH    = 16,
   parameter int                         ADDR_W   = 16,
   parameter logic [ADDR_W-1:0]          BASE     = '0,
   parameter int                         NREGS    = 4,
   parameter logic [NREGS*WIDTH-1:0]     DEFAULTS = '0,
   parameter logic [NREGS-1:0]           W1C_MASK = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   mem_mapped_reg_bank_if.slave     bus,
   input  logic [NREGS*WIDTH-1:0]   hw_set,
   output logic [NREGS*WIDTH-1:0]   reg_out,
   output logic [NREGS-1:0]         wr_pulse
);

   localparam logic [ADDR_W:0] NREGS_EXT = (ADDR_W+1)'(NREGS);

   logic [ADDR_W-1:0]       w_idx;
   logic                    w_hit;
   logic                    w_wr_hit;
   logic                    w_rd_hit;
   logic [NREGS-1:0]        w_wr_dec;
   logic [NREGS*WIDTH-1:0]  w_regs;
   logic [WIDTH-1:0]        w_rd_data;

   logic [WIDTH-1:0]        r_data_out;
   logic                    r_rd_valid;
   logic [NREGS-1:0]        r_wr_pulse;

   // Subtraction wraps, so addresses below BASE land on a large index and miss.
   assign w_idx    = bus.mem_addr - BASE;
   assign w_hit    = ({1'b0, w_idx} < NREGS_EXT);
   assign w_wr_hit = w_hit & bus.mem_wr_en;
   assign w_rd_hit = w_hit & bus.mem_rd_en;

   always_comb begin
      w_wr_dec = '0;
      for (int i = 0; i < NREGS; i++) begin
         w_wr_dec[i] = w_wr_hit & (w_idx == ADDR_W'(i));
      end
   end

   for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [WIDTH-1:0] r_val;

      if (W1C_MASK[gi]) begin : g_w1c
         logic [WIDTH-1:0] w_clr;
         assign w_clr = w_wr_dec[gi] ? bus.data_in : '0;

         // OR-ing the set term last lets hardware win over a same-cycle clear.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_val <= DEFAULTS[gi*WIDTH +: WIDTH];
            end else begin
               r_val <= (r_val & ~w_clr) | hw_set[gi*WIDTH +: WIDTH];
            end
         end
      end else begin : g_plain
         logic w_unused_hw_set;
         assign w_unused_hw_set = ^hw_set[gi*WIDTH +: WIDTH];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_val <= DEFAULTS[gi*WIDTH +: WIDTH];
            end else if (w_wr_dec[gi]) begin
               r_val <= bus.data_in;
            end
         end
      end

      assign w_regs[gi*WIDTH +: WIDTH] = r_val;
   end

   // Read mux uses the pre-edge register values, so a same-cycle write is not seen.
   always_comb begin
      w_rd_data = '0;
      if (w_rd_hit) begin
         for (int i = 0; i < NREGS; i++) begin
            if (w_idx == ADDR_W'(i)) begin
               w_rd_data = w_regs[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_out <= '0;
         r_rd_valid <= 1'b0;
         r_wr_pulse <= '0;
      end else begin
         r_data_out <= w_rd_data;
         r_rd_valid <= w_rd_hit;
         r_wr_pulse <= w_wr_dec;
      end
   end

   assign bus.data_out = r_data_out;
   assign bus.rd_valid = r_rd_valid;
   assign reg_out      = w_regs;
   assign wr_pulse     = r_wr_pulse;

endmodule

// File: tb/tb_mem_mapped_reg_bank.sv
// Bench for mem_mapped_reg_bank: directed scenarios followed by random bus
// traffic, all compared against a behavioural model of the register bank.
module tb_mem_mapped_reg_bank;
   localparam int                 W    = 16;
   localparam int                 AW   = 16;
   localparam int                 N    = 4;
   localparam logic [AW-1:0]      BASE = 16'h0100;
   localparam logic [N*W-1:0]     DEF  = {16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
   localparam logic [N-1:0]       MASK = 4'b0001;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N*W-1:0]  hw_set = '0;
   logic [N*W-1:0]  reg_out;
   logic [N-1:0]    wr_pulse;

   mem_mapped_reg_bank_if #(.ADDR_W(AW), .WIDTH(W)) bus ();

   mem_mapped_reg_bank #(
      .WIDTH(W), .ADDR_W(AW), .BASE(BASE), .NREGS(N),
      .DEFAULTS(DEF), .W1C_MASK(MASK)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .hw_set   (hw_set),
      .reg_out  (reg_out),
      .wr_pulse (wr_pulse)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] m_reg [N];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) m_reg[i] = DEF[i*W +: W];
   endfunction

   function automatic logic [N*W-1:0] model_pack();
      logic [N*W-1:0] v;
      for (int i = 0; i < N; i++) v[i*W +: W] = m_reg[i];
      return v;
   endfunction

   // One bus cycle: drive at negedge, apply the model at the posedge, check #1 later.
   task automatic bus_cycle(input logic [AW-1:0] a, input logic wr, input logic rd,
                            input logic [W-1:0] d, input logic [N*W-1:0] hs);
      logic [AW-1:0] idx;
      logic          hit;
      logic [W-1:0]  e_dout;
      logic          e_vld;
      logic [N-1:0]  e_pulse;
      @(negedge clk);
      bus.mem_addr  = a;
      bus.mem_wr_en = wr;
      bus.mem_rd_en = rd;
      bus.data_in   = d;
      hw_set        = hs;
      @(posedge clk);
      idx     = a - BASE;
      hit     = (idx < N);
      e_vld   = hit && rd;
      e_dout  = e_vld ? m_reg[idx[1:0]] : '0;
      e_pulse = (hit && wr) ? (N'(1) << idx[1:0]) : '0;
      for (int i = 0; i < N; i++) begin
         if (MASK[i]) begin
            m_reg[i] = (m_reg[i] & ~((hit && wr && idx == i) ? d : W'(0))) | hs[i*W +: W];
         end else if (hit && wr && idx == i) begin
            m_reg[i] = d;
         end
      end
      #1;
      chk("data_out", 64'(bus.data_out), 64'(e_dout));
      chk("rd_valid", 64'(bus.rd_valid), 64'(e_vld));
      chk("wr_pulse", 64'(wr_pulse), 64'(e_pulse));
      chk("reg_out",  64'(reg_out), 64'(model_pack()));
   endtask

   logic [N*W-1:0] snap;

   initial begin
      bus.mem_addr  = '0;
      bus.mem_wr_en = 1'b0;
      bus.mem_rd_en = 1'b0;
      bus.data_in   = '0;
      model_reset();

      // Reset state
      #12;
      chk("rst_reg_out",  64'(reg_out), 64'(DEF));
      chk("rst_reg1",     64'(reg_out[W +: W]), 64'h BEEF);
      chk("rst_data_out", 64'(bus.data_out), 64'h0);
      chk("rst_rd_valid", 64'(bus.rd_valid), 64'h0);
      chk("rst_wr_pulse", 64'(wr_pulse), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // Plain write then read of reg2
      bus_cycle(16'h0102, 1'b1, 1'b0, 16'h1234, '0);
      chk("t2_wr_pulse", 64'(wr_pulse), 64'h4);
      bus_cycle(16'h0102, 1'b0, 1'b1, 16'h0000, '0);
      chk("t2_data_out", 64'(bus.data_out), 64'h1234);
      chk("t2_rd_valid", 64'(bus.rd_valid), 64'h1);
      chk("t2_pulse_gone", 64'(wr_pulse), 64'h0);

      // Decode edges
      bus_cycle(16'h00FF, 1'b0, 1'b1, 16'h0000, '0);
      chk("t3_below_base", 64'({bus.rd_valid, bus.data_out}), 64'h0);
      bus_cycle(16'h0104, 1'b0, 1'b1, 16'h0000, '0);
      chk("t3_above_top", 64'({bus.rd_valid, bus.data_out}), 64'h0);
      bus_cycle(16'h0103, 1'b0, 1'b1, 16'h0000, '0);
      chk("t3_top_hit", 64'(bus.rd_valid), 64'h1);
      snap = reg_out;
      bus_cycle(16'h00FF, 1'b1, 1'b0, 16'hFFFF, '0);
      chk("t3_miss_write", 64'(reg_out), 64'(snap));

      // Sticky reg0: set, clear, set-wins
      bus_cycle(16'h0000, 1'b0, 1'b0, 16'h0000, 64'h00F0);
      chk("t4_set", 64'(reg_out[0 +: W]), 64'h00F0);
      bus_cycle(16'h0100, 1'b1, 1'b0, 16'h0030, '0);
      chk("t4_clear", 64'(reg_out[0 +: W]), 64'h00C0);
      bus_cycle(16'h0100, 1'b1, 1'b0, 16'h0040, 64'h0040);
      chk("t4_set_wins", 64'(reg_out[0 +: W]), 64'h00C0);
      chk("t4_w1c_pulse", 64'(wr_pulse), 64'h1);
      // hw_set on plain regs is ignored
      bus_cycle(16'h0000, 1'b0, 1'b0, 16'h0000, 64'hFFFF_FFFF_FFFF_0000);
      chk("t4_plain_ignore", 64'(reg_out[W +: 3*W]), 64'h0000_1234_BEEF);

      // Same-cycle read and write of reg1
      bus_cycle(16'h0101, 1'b1, 1'b1, 16'h5555, '0);
      chk("t5_old_value", 64'(bus.data_out), 64'hBEEF);
      chk("t5_new_value", 64'(reg_out[W +: W]), 64'h5555);

      // Async reset in the middle of a write
      @(negedge clk);
      bus.mem_addr  = 16'h0102;
      bus.mem_wr_en = 1'b1;
      bus.mem_rd_en = 1'b1;
      bus.data_in   = 16'hFFFF;
      hw_set        = '0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk("t6_async_regs", 64'(reg_out), 64'(DEF));
      chk("t6_async_rd",   64'({bus.rd_valid, bus.data_out}), 64'h0);
      @(posedge clk);
      #1;
      chk("t6_write_lost", 64'(reg_out), 64'(DEF));
      chk("t6_no_pulse",   64'(wr_pulse), 64'h0);
      @(negedge clk);
      rst           = 1'b0;
      bus.mem_wr_en = 1'b0;
      bus.mem_rd_en = 1'b0;
      bus_cycle(16'h0103, 1'b1, 1'b0, 16'hA5A5, '0);
      bus_cycle(16'h0103, 1'b0, 1'b1, 16'h0000, '0);
      chk("t6_after_rst", 64'(bus.data_out), 64'hA5A5);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         logic [AW-1:0]  a;
         logic [N*W-1:0] hs;
         a  = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'(16'h00FE + $urandom_range(0, 7));
         hs = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) hs = '0;
         bus_cycle(a, 1'($urandom), 1'($urandom), W'($urandom), hs);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
